// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the four-lane TDM demultiplexer.
//   state_e   : frame-lock state (hunting for slot 0, or locked to the frame)
//   slot_t    : 2-bit slot index within a frame
//   LANE_A..D : slot index of each output lane
//   NUM_LANES : lanes per frame
package tdm_demux_pkg;

  typedef enum logic [0:0] {
    StHunt,
    StLocked
  } state_e;

  typedef logic [1:0] slot_t;

  localparam int unsigned NUM_LANES = 4;

  localparam slot_t LANE_A = 2'd0;
  localparam slot_t LANE_B = 2'd1;
  localparam slot_t LANE_C = 2'd2;
  localparam slot_t LANE_D = 2'd3;

endpackage

// File: rtl/tdm_demux4.sv
// Four-lane time-division demultiplexer. A W-bit stream carries slots 0..3 in rotation,
// with frame_sync marking slot 0. The block locks onto the frame, collects slots 0..2 in a
// shadow bank and, on the slot-3 beat, presents all four lanes together with a one-cycle
// frame_valid pulse. Lock survives up to FLYWHEEL-1 consecutive frames whose slot-0 beat
// lacks frame_sync; the next such beat is dropped and the block returns to hunting.
//
// Optional build macro: TDM_DEMUX_PARITY_EN adds din_par (even parity over din) and
// parity_err; a frame with any parity mismatch is suppressed and parity_err pulses instead.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   din         in   W-bit stream beat
//   din_valid   in   beat qualifier
//   frame_sync  in   current valid beat is slot 0
//   din_par     in   even parity of din (TDM_DEMUX_PARITY_EN only)
//   a, b, c, d  out  lane registers for slots 0..3
//   frame_valid out  one-cycle pulse, a..d updated this cycle
//   s1, s0      out  next expected slot
//   locked      out  high while locked to the frame
//   sync_err    out  one-cycle pulse after a misaligned frame_sync
//   parity_err  out  one-cycle pulse for a suppressed frame (TDM_DEMUX_PARITY_EN only)
module tdm_demux4
  import tdm_demux_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter int unsigned FLYWHEEL = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         frame_sync,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic         din_par,
  output logic         parity_err,
`endif
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic         frame_valid,
  output logic         s1,
  output logic         s0,
  output logic         locked,
  output logic         sync_err
);

  localparam logic [3:0] FlyMax = 4'(FLYWHEEL);

  state_e         state_q, state_d;
  slot_t          slot_q, slot_d;
  logic [3:0]     miss_q, miss_d;
  logic [3:0]     miss_inc;
  logic [W-1:0]   shadow_q [3];
  logic [W-1:0]   shadow_d [3];
  logic [W-1:0]   lanes_q [NUM_LANES];
  logic [W-1:0]   lanes_d [NUM_LANES];
  logic           fv_q, fv_d;
  logic           serr_q, serr_d;
  // Frame has seen a parity mismatch; constant 0 when parity is not built in.
  logic           bad_q, bad_d;
  logic           beat_bad;

`ifdef TDM_DEMUX_PARITY_EN
  logic           perr_q, perr_d;
  assign beat_bad = din_par ^ (^din);
`else
  assign beat_bad = 1'b0;
`endif

  assign miss_inc = miss_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    miss_d   = miss_q;
    shadow_d = shadow_q;
    lanes_d  = lanes_q;
    bad_d    = bad_q;
    fv_d     = 1'b0;
    serr_d   = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    perr_d   = 1'b0;
`endif

    if (din_valid) begin
      case (state_q)
        StHunt: begin
          if (frame_sync) begin
            shadow_d[0] = din;
            slot_d      = LANE_B;
            state_d     = StLocked;
            miss_d      = '0;
            bad_d       = beat_bad;
          end
        end

        StLocked: begin
          if (slot_q == LANE_A) begin
            if (!frame_sync && (miss_inc == FlyMax)) begin
              // Flywheel exhausted: drop this beat and go back to hunting.
              state_d = StHunt;
              slot_d  = LANE_A;
              miss_d  = '0;
              bad_d   = 1'b0;
            end else begin
              shadow_d[0] = din;
              slot_d      = LANE_B;
              miss_d      = frame_sync ? 4'd0 : miss_inc;
              bad_d       = beat_bad;
            end
          end else if (frame_sync) begin
            // Misaligned sync: discard the partial frame and restart on this beat.
            serr_d      = 1'b1;
            shadow_d[0] = din;
            slot_d      = LANE_B;
            miss_d      = '0;
            bad_d       = beat_bad;
          end else begin
            slot_d = slot_q + 2'd1;
            if (slot_q == LANE_B) begin
              shadow_d[1] = din;
              bad_d       = bad_q | beat_bad;
            end else if (slot_q == LANE_C) begin
              shadow_d[2] = din;
              bad_d       = bad_q | beat_bad;
            end else begin
              bad_d = 1'b0;
              if (bad_q || beat_bad) begin
`ifdef TDM_DEMUX_PARITY_EN
                perr_d = 1'b1;
`endif
              end else begin
                lanes_d[LANE_A] = shadow_q[0];
                lanes_d[LANE_B] = shadow_q[1];
                lanes_d[LANE_C] = shadow_q[2];
                lanes_d[LANE_D] = din;
                fv_d            = 1'b1;
              end
            end
          end
        end

        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StHunt;
      slot_q   <= LANE_A;
      miss_q   <= '0;
      shadow_q <= '{default: '0};
      lanes_q  <= '{default: '0};
      bad_q    <= 1'b0;
      fv_q     <= 1'b0;
      serr_q   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      miss_q   <= miss_d;
      shadow_q <= shadow_d;
      lanes_q  <= lanes_d;
      bad_q    <= bad_d;
      fv_q     <= fv_d;
      serr_q   <= serr_d;
`ifdef TDM_DEMUX_PARITY_EN
      perr_q   <= perr_d;
`endif
    end
  end

  assign a           = lanes_q[LANE_A];
  assign b           = lanes_q[LANE_B];
  assign c           = lanes_q[LANE_C];
  assign d           = lanes_q[LANE_D];
  assign frame_valid = fv_q;
  assign sync_err    = serr_q;
  assign s1          = slot_q[1];
  assign s0          = slot_q[0];
  assign locked      = (state_q == StLocked);
`ifdef TDM_DEMUX_PARITY_EN
  assign parity_err  = perr_q;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed scenarios plus a randomized stream, all checked
// against a queue-based frame model.
module tb_tdm_demux4;

  localparam int unsigned W        = 8;
  localparam int unsigned FLYWHEEL = 3;
  localparam int unsigned VW       = 4 * W + 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         frame_sync = 1'b0;
  logic [W-1:0] a, b, c, d;
  logic         frame_valid, s1, s0, locked, sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic         din_par = 1'b0;
  logic         parity_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int fv_seen = 0;

  tdm_demux4 #(.W(W), .FLYWHEEL(FLYWHEEL)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
`ifdef TDM_DEMUX_PARITY_EN
    .din_par    (din_par),
    .parity_err (parity_err),
`endif
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .frame_valid(frame_valid),
    .s1         (s1),
    .s0         (s0),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  // Reference model: the current partial frame is a queue; its length is the next slot.
  logic [W-1:0] m_lane [4];
  logic [W-1:0] m_frame [$];
  bit           m_fv, m_serr, m_perr, m_locked, m_bad;
  int           m_miss;

  task automatic model_step(input bit r, input bit v, input bit s, input logic [W-1:0] dd,
                            input bit pb);
    m_fv   = 0;
    m_serr = 0;
    m_perr = 0;
    if (r) begin
      for (int k = 0; k < 4; k++) m_lane[k] = '0;
      m_locked = 0;
      m_miss   = 0;
      m_bad    = 0;
      m_frame.delete();
    end else if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_locked = 1;
          m_frame.delete();
          m_frame.push_back(dd);
          m_miss = 0;
          m_bad  = pb;
        end
      end else if (m_frame.size() == 0) begin
        if (s) m_miss = 0;
        else   m_miss++;
        if (!s && m_miss >= FLYWHEEL) begin
          m_locked = 0;
          m_miss   = 0;
        end else begin
          m_frame.push_back(dd);
          m_bad = pb;
        end
      end else if (s) begin
        m_serr = 1;
        m_frame.delete();
        m_frame.push_back(dd);
        m_miss = 0;
        m_bad  = pb;
      end else begin
        m_frame.push_back(dd);
        m_bad = m_bad | pb;
        if (m_frame.size() == 4) begin
          if (m_bad) m_perr = 1;
          else begin
            for (int k = 0; k < 4; k++) m_lane[k] = m_frame[k];
            m_fv = 1;
          end
          m_frame.delete();
          m_bad = 0;
        end
      end
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [1:0] sl;
    sl = 2'(m_frame.size());
    return {m_lane[0], m_lane[1], m_lane[2], m_lane[3], m_fv, m_serr, m_locked, sl, m_perr};
  endfunction

  function automatic logic [VW-1:0] obs();
    logic pe;
`ifdef TDM_DEMUX_PARITY_EN
    pe = parity_err;
`else
    pe = 1'b0;
`endif
    return {a, b, c, d, frame_valid, sync_err, locked, s1, s0, pe};
  endfunction

  // One clock: drive inputs, let the edge happen, advance the model, settle past the edge.
  task automatic step(input bit r, input bit v, input bit s, input logic [W-1:0] dd,
                      input bit pb);
    bit pb_eff;
`ifdef TDM_DEMUX_PARITY_EN
    pb_eff  = pb;
    din_par = (^dd) ^ pb;
`else
    pb_eff  = 1'b0;
`endif
    rst        = r;
    din_valid  = v;
    frame_sync = s;
    din        = dd;
    @(posedge clk);
    model_step(r, v, s, dd, pb_eff);
    #1;
    if (frame_valid === 1'b1) fv_seen++;
  endtask

  task automatic test_reset();
    step(1, 0, 0, '0, 0);
    step(1, 1, 1, 8'h5a, 0);
    n_tests++;
    if (obs() !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", obs(), {VW{1'b0}});
    end
    n_tests++;
    if (obs() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_model: got %h want %h", obs(), exp_vec());
    end
  endtask

  task automatic test_basic();
    step(0, 1, 1, 8'h11, 0);
    step(0, 1, 0, 8'h22, 0);
    step(0, 1, 0, 8'h33, 0);
    n_tests++;
    if ({locked, s1, s0, frame_valid} !== 4'b1110) begin
      n_fail++;
      $display("FAIL basic_midframe: got %b want %b", {locked, s1, s0, frame_valid}, 4'b1110);
    end
    step(0, 1, 0, 8'h44, 0);
    n_tests++;
    if ({a, b, c, d, frame_valid, locked} !== {32'h11223344, 2'b11}) begin
      n_fail++;
      $display("FAIL basic_frame: got %h want %h", {a, b, c, d, frame_valid, locked},
               {32'h11223344, 2'b11});
    end
    step(0, 0, 0, '0, 0);
    n_tests++;
    if ({frame_valid, a, d} !== {1'b0, 8'h11, 8'h44}) begin
      n_fail++;
      $display("FAIL basic_hold: got %h want %h", {frame_valid, a, d}, {1'b0, 8'h11, 8'h44});
    end
  endtask

  task automatic test_hunt_noise();
    step(1, 0, 0, '0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 8'haa, 0);
      n_tests++;
      if ({locked, frame_valid, a, b, c, d} !== '0) begin
        n_fail++;
        $display("FAIL hunt_noise beat %0d: got %h want 0", i,
                 {locked, frame_valid, a, b, c, d});
      end
    end
  endtask

  task automatic test_flywheel();
    logic [W-1:0] v;
    step(1, 0, 0, '0, 0);
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        v = 8'(((f + 1) << 4) | (k + 1));
        step(0, 1, (f == 0) && (k == 0), v, 0);
        n_tests++;
        if (obs() !== exp_vec()) begin
          n_fail++;
          $display("FAIL flywheel f%0d k%0d: got %h want %h", f, k, obs(), exp_vec());
        end
      end
    end
    n_tests++;
    if ({a, b, c, d, locked} !== {32'h31323334, 1'b1}) begin
      n_fail++;
      $display("FAIL flywheel_frame3: got %h want %h", {a, b, c, d, locked},
               {32'h31323334, 1'b1});
    end
    step(0, 1, 0, 8'h41, 0);
    n_tests++;
    if ({locked, s1, s0, frame_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL flywheel_drop: got %b want 0000", {locked, s1, s0, frame_valid});
    end
    step(0, 1, 0, 8'h42, 0);
    n_tests++;
    if (obs() !== exp_vec()) begin
      n_fail++;
      $display("FAIL flywheel_after: got %h want %h", obs(), exp_vec());
    end
  endtask

  task automatic test_realign();
    step(1, 0, 0, '0, 0);
    step(0, 1, 1, 8'h11, 0);
    step(0, 1, 0, 8'h22, 0);
    step(0, 1, 1, 8'h99, 0);
    n_tests++;
    if ({sync_err, frame_valid, locked, s1, s0} !== 5'b10101) begin
      n_fail++;
      $display("FAIL realign_err: got %b want 10101", {sync_err, frame_valid, locked, s1, s0});
    end
    step(0, 1, 0, 8'haa, 0);
    n_tests++;
    if (sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL realign_pulse: got %b want 0", sync_err);
    end
    step(0, 1, 0, 8'hbb, 0);
    step(0, 1, 0, 8'hcc, 0);
    n_tests++;
    if ({a, b, c, d, frame_valid} !== {32'h99aabbcc, 1'b1}) begin
      n_fail++;
      $display("FAIL realign_frame: got %h want %h", {a, b, c, d, frame_valid},
               {32'h99aabbcc, 1'b1});
    end
  endtask

  task automatic test_gaps();
    int fv0;
    step(1, 0, 0, '0, 0);
    fv0 = fv_seen;
    for (int k = 0; k < 4; k++) begin
      step(0, 1, k == 0, 8'(k + 1), 0);
      step(0, 0, 1, 8'hff, 0);
    end
    n_tests++;
    if ({a, b, c, d} !== 32'h01020304 || fv_seen - fv0 !== 1) begin
      n_fail++;
      $display("FAIL gaps: got %h fv=%0d want 01020304 fv=1", {a, b, c, d}, fv_seen - fv0);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 0, 0, '0, 0);
    for (int j = 0; j < 12; j++) begin
      step(0, 1, (j % 4) == 0, 8'($urandom), 0);
      n_tests++;
      if (frame_valid !== ((j % 4) == 3) || obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL back_to_back j%0d: got %h want %h", j, obs(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_midframe();
    step(0, 1, 1, 8'h55, 0);
    step(0, 1, 0, 8'h66, 0);
    step(1, 1, 0, 8'h77, 0);
    n_tests++;
    if (obs() !== '0) begin
      n_fail++;
      $display("FAIL reset_midframe: got %h want 0", obs());
    end
    step(0, 1, 1, 8'h71, 0);
    step(0, 1, 0, 8'h72, 0);
    step(0, 1, 0, 8'h73, 0);
    step(0, 1, 0, 8'h74, 0);
    n_tests++;
    if ({a, b, c, d, frame_valid} !== {32'h71727374, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_fresh: got %h want %h", {a, b, c, d, frame_valid},
               {32'h71727374, 1'b1});
    end
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  task automatic test_parity();
    step(1, 0, 0, '0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, k == 0, 8'(8'h11 * (k + 1)), 0);
    for (int k = 0; k < 4; k++) step(0, 1, k == 0, 8'(8'h51 + k), k == 1);
    n_tests++;
    if ({parity_err, frame_valid, a, b, c, d} !== {2'b10, 32'h11223344}) begin
      n_fail++;
      $display("FAIL parity_bad: got %h want %h", {parity_err, frame_valid, a, b, c, d},
               {2'b10, 32'h11223344});
    end
    step(0, 0, 0, '0, 0);
    n_tests++;
    if (parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_pulse: got %b want 0", parity_err);
    end
  endtask
`endif

  task automatic test_random();
    bit r, v, s, pb;
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      v  = ($urandom_range(0, 3) != 0);
      s  = (m_frame.size() == 0) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 19) == 0);
      pb = ($urandom_range(0, 24) == 0);
      step(r, v, s, 8'($urandom), pb);
      n_tests++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h want %h", i, obs(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hunt_noise();
    test_flywheel();
    test_realign();
    test_gaps();
    test_back_to_back();
    test_reset_midframe();
`ifdef TDM_DEMUX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
